// File: rtl/cl_decode_queue.sv
// cl_decode_queue: decodes each accepted instruction into a control bundle.
// The instruction and its bundle are stored together in a DEPTH-entry FIFO
// that sits between fetch and register-read/execute. Both sides use
// valid/ready handshakes, and flush_i drops everything that is queued.
// Optional build macro DECODE_PERF_CNT_EN adds the stall_cycles_o counter,
// which counts the cycles where input stalled because the queue was full.

package cl_decode_pkg;
    typedef logic [31:0] instruction_s;

    typedef struct packed {
        logic is_load_op;
        logic op_writes_rf;
        logic is_mem_op;
        logic is_store_op;
        logic is_byte_op;
    } ctrl_sig_s;

    // Instruction encodings, matched with casez ('?' = don't care)
    localparam instruction_s kADDU = 32'b000000_?????_?????_?????_00000_100001;
    localparam instruction_s kSUBU = 32'b000000_?????_?????_?????_00000_100011;
    localparam instruction_s kSLLV = 32'b000000_?????_?????_?????_00000_000100;
    localparam instruction_s kSRAV = 32'b000000_?????_?????_?????_00000_000111;
    localparam instruction_s kSRLV = 32'b000000_?????_?????_?????_00000_000110;
    localparam instruction_s kAND  = 32'b000000_?????_?????_?????_00000_100100;
    localparam instruction_s kOR   = 32'b000000_?????_?????_?????_00000_100101;
    localparam instruction_s kNOR  = 32'b000000_?????_?????_?????_00000_100111;
    localparam instruction_s kSLT  = 32'b000000_?????_?????_?????_00000_101010;
    localparam instruction_s kSLTU = 32'b000000_?????_?????_?????_00000_101011;
    localparam instruction_s kMOV  = 32'b000000_?????_?????_?????_00000_001010;
    localparam instruction_s kJALR = 32'b000000_?????_00000_?????_00000_001001;
    localparam instruction_s kLW   = 32'b100011_?????_?????_????????????????;
    localparam instruction_s kLBU  = 32'b100100_?????_?????_????????????????;
    localparam instruction_s kSW   = 32'b101011_?????_?????_????????????????;
    localparam instruction_s kSB   = 32'b101000_?????_?????_????????????????;

    function automatic ctrl_sig_s decode(input instruction_s instr);
        ctrl_sig_s c;
        c = '0;
        casez (instr)
            kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR,
            kSLT, kSLTU, kMOV, kJALR: c.op_writes_rf = 1'b1;
            kLW: begin
                c.is_load_op   = 1'b1;
                c.op_writes_rf = 1'b1;
                c.is_mem_op    = 1'b1;
            end
            kLBU: begin
                c.is_load_op   = 1'b1;
                c.op_writes_rf = 1'b1;
                c.is_mem_op    = 1'b1;
                c.is_byte_op   = 1'b1;
            end
            kSW: begin
                c.is_mem_op    = 1'b1;
                c.is_store_op  = 1'b1;
            end
            kSB: begin
                c.is_mem_op    = 1'b1;
                c.is_store_op  = 1'b1;
                c.is_byte_op   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction
endpackage

module cl_decode_queue
    import cl_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic                        instr_valid_i,
    output logic                        instr_ready_o,
    input  logic [$bits(instruction_s)-1:0] instruction_i,
    output logic                        dec_valid_o,
    input  logic                        dec_ready_i,
    output logic [$bits(instruction_s)-1:0] instruction_o,
    output logic [$bits(ctrl_sig_s)-1:0]    ctrl_sig_o,
    output logic [CNT_W-1:0]            count_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]                 stall_cycles_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    instruction_s instr_mem_q [DEPTH];
    ctrl_sig_s    ctrl_mem_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             enq, deq;

    // Handshakes and next-state for pointers/occupancy; flush wins over both sides
    always_comb begin
        instr_ready_o = !reset && (count_q != CNT_W'(DEPTH));
        dec_valid_o   = (count_q != '0);
        enq           = instr_valid_i && instr_ready_o && !flush_i;
        deq           = dec_valid_o && dec_ready_i && !flush_i;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset outranks flush
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: decode once at enqueue, never again at the head
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem_q[wr_ptr_q] <= instruction_i;
            ctrl_mem_q[wr_ptr_q]  <= decode(instruction_i);
        end
    end

    // Head outputs masked to zero when empty so nothing spurious leaks downstream
    always_comb begin
        count_o       = count_q;
        instruction_o = dec_valid_o ? instr_mem_q[rd_ptr_q] : '0;
        ctrl_sig_o    = dec_valid_o ? ctrl_mem_q[rd_ptr_q]  : '0;
    end

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of cycles where fetch offered input and the queue could not take it
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (instr_valid_i && !instr_ready_o && !reset && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Stall counter register; cleared by reset only, flush leaves it alone
    always_ff @(posedge clk) begin
        if (reset) stall_cycles_q <= '0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cl_decode_queue.sv
// Directed bench for cl_decode_queue (DEPTH=4). Inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_cl_decode_queue;
    import cl_decode_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic        clk = 1'b0;
    logic        reset, flush_i, instr_valid_i, instr_ready_o;
    logic [31:0] instruction_i, instruction_o;
    logic        dec_valid_o, dec_ready_i;
    logic [4:0]  ctrl_sig_o;
    logic [CNT_W-1:0] count_o;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cycles_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cl_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instruction_i (instruction_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .instruction_o (instruction_o),
        .ctrl_sig_o    (ctrl_sig_o),
        .count_o       (count_o)
`ifdef DECODE_PERF_CNT_EN
        ,
        .stall_cycles_o(stall_cycles_o)
`endif
    );

    // Expected control bundles: {load, writes_rf, mem, store, byte}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_ALU  = 5'b01000;
    localparam logic [4:0] C_LW   = 5'b11100;
    localparam logic [4:0] C_SB   = 5'b00111;

    function automatic logic [31:0] mk_r(input logic [5:0] funct, input logic [4:0] rd);
        return {6'b000000, 5'd1, 5'd2, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd4, 5'd5, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] addu, jalr, nor_i, lw, sb, sw;
    logic [31:0] fill [4];
    logic [31:0] q [$];
    logic [31:0] w;
    int          mcnt;

    initial begin
        addu  = mk_r(6'b100001, 5'd3);
        nor_i = mk_r(6'b100111, 5'd7);
        jalr  = {6'b000000, 5'd9, 5'd0, 5'd31, 5'b00000, 6'b001001};
        lw    = mk_i(6'b100011, 16'h0010);
        sb    = mk_i(6'b101000, 16'h0003);
        sw    = mk_i(6'b101011, 16'h0020);
        for (int i = 0; i < 4; i++) fill[i] = mk_r(6'b100011, 5'(10 + i)); // SUBU

        reset = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; dec_ready_i = 1'b0;
        instruction_i = '0;
        tick(); tick();
        check("ready_in_reset", 32'(instr_ready_o), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_ready", 32'(instr_ready_o), 32'd1);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(dec_valid_o), 32'd0);
        check("rst_instr", instruction_o, 32'd0);
        check("rst_ctrl", 32'(ctrl_sig_o), 32'(C_NONE));

        // 1: single ADDU held until consumed
        instr_valid_i = 1'b1; instruction_i = addu;
        tick();
        instr_valid_i = 1'b0;
        check("t1_valid", 32'(dec_valid_o), 32'd1);
        check("t1_count", 32'(count_o), 32'd1);
        check("t1_ctrl", 32'(ctrl_sig_o), 32'(C_ALU));
        check("t1_instr", instruction_o, addu);
        tick();
        check("t1_hold", 32'(count_o), 32'd1);
        dec_ready_i = 1'b1;
        tick();
        dec_ready_i = 1'b0;
        check("t1_drained", 32'(dec_valid_o), 32'd0);
        check("t1_ctrl0", 32'(ctrl_sig_o), 32'(C_NONE));

        // 2: fill to DEPTH, then hold a 5th instruction
        instr_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instruction_i = fill[i];
            tick();
            check("t2_count", 32'(count_o), 32'(i + 1));
        end
        check("t2_ready_full", 32'(instr_ready_o), 32'd0);
        instruction_i = addu;
        for (int i = 0; i < 3; i++) tick();
        check("t2_held_count", 32'(count_o), 32'd4);
        check("t2_head", instruction_o, fill[0]);
`ifdef DECODE_PERF_CNT_EN
        check("t2_stall", stall_cycles_o, 32'd3);
`endif

        // 3: full with pop and push offered together -> pop only
        dec_ready_i = 1'b1;
        tick();
        instr_valid_i = 1'b0; dec_ready_i = 1'b0;
        check("t3_count", 32'(count_o), 32'd3);
        check("t3_ready", 32'(instr_ready_o), 32'd1);
        check("t3_head", instruction_o, fill[1]);
`ifdef DECODE_PERF_CNT_EN
        check("t3_stall", stall_cycles_o, 32'd4);
`endif

        // 5: flush at count 3 with a valid SW in the same cycle
        flush_i = 1'b1; instr_valid_i = 1'b1; instruction_i = sw;
        tick();
        flush_i = 1'b0; instr_valid_i = 1'b0;
        check("t5_count", 32'(count_o), 32'd0);
        check("t5_valid", 32'(dec_valid_o), 32'd0);
        check("t5_instr", instruction_o, 32'd0);
        check("t5_ready", 32'(instr_ready_o), 32'd1);
        tick();
        check("t5_sw_dropped", 32'(count_o), 32'd0);
`ifdef DECODE_PERF_CNT_EN
        check("t5_stall_kept", stall_cycles_o, 32'd4);
`endif

        // 4: ordering and per-entry decode
        instr_valid_i = 1'b1;
        instruction_i = sb;    tick();
        instruction_i = lw;    tick();
        instruction_i = nor_i; tick();
        instruction_i = jalr;  tick();
        instr_valid_i = 1'b0;
        check("t4_full", 32'(count_o), 32'd4);
        dec_ready_i = 1'b1;
        check("t4_sb_ctrl", 32'(ctrl_sig_o), 32'(C_SB));
        check("t4_sb_instr", instruction_o, sb);
        tick();
        check("t4_lw_ctrl", 32'(ctrl_sig_o), 32'(C_LW));
        check("t4_lw_instr", instruction_o, lw);
        tick();
        check("t4_nor_ctrl", 32'(ctrl_sig_o), 32'(C_ALU));
        check("t4_nor_instr", instruction_o, nor_i);
        tick();
        check("t4_jalr_ctrl", 32'(ctrl_sig_o), 32'(C_ALU));
        check("t4_jalr_instr", instruction_o, jalr);
        tick();
        dec_ready_i = 1'b0;
        check("t4_empty_valid", 32'(dec_valid_o), 32'd0);
        check("t4_empty_ctrl", 32'(ctrl_sig_o), 32'(C_NONE));

        // 6: reset mid-stream at count 2
        instr_valid_i = 1'b1;
        instruction_i = addu; tick();
        instruction_i = lw;   tick();
        instr_valid_i = 1'b0;
        check("t6_pre_count", 32'(count_o), 32'd2);
        reset = 1'b1;
        tick();
        check("t6_ready_in_reset", 32'(instr_ready_o), 32'd0);
        reset = 1'b0;
        tick();
        check("t6_count", 32'(count_o), 32'd0);
        check("t6_valid", 32'(dec_valid_o), 32'd0);
        check("t6_instr", instruction_o, 32'd0);
        check("t6_ctrl", 32'(ctrl_sig_o), 32'(C_NONE));
        check("t6_ready", 32'(instr_ready_o), 32'd1);
`ifdef DECODE_PERF_CNT_EN
        check("t6_stall_clr", stall_cycles_o, 32'd0);
`endif

        // 6b: pointer wrap under 3*DEPTH continuous push/pop
        q.delete();
        mcnt = 0;
        instr_valid_i = 1'b1; dec_ready_i = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            w = mk_i(6'b100011, 16'(16'h100 + i));
            instruction_i = w;
            tick();
            if (mcnt > 0) begin
                void'(q.pop_front());
                mcnt--;
            end
            q.push_back(w);
            mcnt++;
            check("t6_wrap_count", 32'(count_o), 32'(mcnt));
            check("t6_wrap_head", instruction_o, q[0]);
            check("t6_wrap_ctrl", 32'(ctrl_sig_o), 32'(C_LW));
        end
        instr_valid_i = 1'b0;
        tick();
        check("t6_wrap_drain", 32'(count_o), 32'd0);
        dec_ready_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
